// File: rtl/mul_div_unit_pkg.sv
// Shared control encodings for the EX stage: ALU op codes and MDU op codes.
// Also holds the MDU cycle-counter width and a small op-classification helper.
package mul_div_unit_pkg;

    localparam logic [3:0] ALUCtrl_ADD  = 4'd0;
    localparam logic [3:0] ALUCtrl_SUB  = 4'd1;
    localparam logic [3:0] ALUCtrl_AND  = 4'd2;
    localparam logic [3:0] ALUCtrl_OR   = 4'd3;
    localparam logic [3:0] ALUCtrl_XOR  = 4'd4;
    localparam logic [3:0] ALUCtrl_NOR  = 4'd5;
    localparam logic [3:0] ALUCtrl_SLT  = 4'd6;
    localparam logic [3:0] ALUCtrl_SLTU = 4'd7;
    localparam logic [3:0] ALUCtrl_LUI  = 4'd8;

    localparam logic [3:0] MDUCtrl_NONE  = 4'd0;
    localparam logic [3:0] MDUCtrl_MULT  = 4'd1;
    localparam logic [3:0] MDUCtrl_MULTU = 4'd2;
    localparam logic [3:0] MDUCtrl_DIV   = 4'd3;
    localparam logic [3:0] MDUCtrl_DIVU  = 4'd4;
    localparam logic [3:0] MDUCtrl_MTHI  = 4'd5;
    localparam logic [3:0] MDUCtrl_MTLO  = 4'd6;
    localparam logic [3:0] MDUCtrl_MFHI  = 4'd7;
    localparam logic [3:0] MDUCtrl_MFLO  = 4'd8;

    localparam int MDU_CNT_W = 16;

    function automatic logic is_long_op(input logic [3:0] ctrl);
        return (ctrl == MDUCtrl_MULT) || (ctrl == MDUCtrl_MULTU) ||
               (ctrl == MDUCtrl_DIV)  || (ctrl == MDUCtrl_DIVU);
    endfunction

endpackage

// File: rtl/mdu_counter.sv
// Busy window generator: loads a cycle count and holds busy for exactly that
// many cycles; done_o marks the final busy cycle, whose closing edge drops busy.
module mdu_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             busy_o,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (busy_q) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
            end
        end else if (load_i) begin
            cnt_d  = load_val_i;
            // a zero-length window would underflow the count, so never start one
            busy_d = (load_val_i != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Operands are latched at issue; the result is computed and written when busy falls.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  MDUCtrl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] out
);

    logic [3:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        accept, load, done;
    logic [MDU_CNT_W-1:0] load_val;

    logic [63:0]        prod_s, prod_u;
    logic signed [31:0] sa, sb_safe, quot_s, rem_s;
    logic [31:0]        ub_safe, quot_u, rem_u;
    logic               div_ovf;

    assign accept   = start && !busy;
    assign load     = accept && is_long_op(MDUCtrl);
    assign load_val = ((MDUCtrl == MDUCtrl_DIV) || (MDUCtrl == MDUCtrl_DIVU)) ?
                      MDU_CNT_W'(DIV_CYCLES) : MDU_CNT_W'(MULT_CYCLES);

    mdu_counter #(.CNT_W(MDU_CNT_W)) u_counter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load),
        .load_val_i (load_val),
        .busy_o     (busy),
        .done_o     (done)
    );

    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'b0, a_q} * {32'b0, b_q};

    // Dividing by 1 in the overflow case yields the wrapped quotient 0x80000000, remainder 0.
    assign div_ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    assign sa      = $signed(a_q);
    assign sb_safe = ((b_q == '0) || div_ovf) ? 32'sd1 : $signed(b_q);
    assign quot_s  = sa / sb_safe;
    assign rem_s   = sa % sb_safe;
    assign ub_safe = (b_q == '0) ? 32'd1 : b_q;
    assign quot_u  = a_q / ub_safe;
    assign rem_u   = a_q % ub_safe;

    always_comb begin
        op_d = op_q;
        a_d  = a_q;
        b_d  = b_q;
        hi_d = hi_q;
        lo_d = lo_q;
        if (done) begin
            case (op_q)
                MDUCtrl_MULT:  {hi_d, lo_d} = prod_s;
                MDUCtrl_MULTU: {hi_d, lo_d} = prod_u;
                MDUCtrl_DIV: begin
                    if (b_q != '0) begin
                        hi_d = rem_s;
                        lo_d = quot_s;
                    end
                end
                MDUCtrl_DIVU: begin
                    if (b_q != '0) begin
                        hi_d = rem_u;
                        lo_d = quot_u;
                    end
                end
                default: ;
            endcase
        end else if (accept) begin
            if (is_long_op(MDUCtrl)) begin
                op_d = MDUCtrl;
                a_d  = A;
                b_d  = B;
            end else if (MDUCtrl == MDUCtrl_MTHI) begin
                hi_d = A;
            end else if (MDUCtrl == MDUCtrl_MTLO) begin
                lo_d = A;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q <= MDUCtrl_NONE;
            a_q  <= '0;
            b_q  <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            op_q <= op_d;
            a_q  <= a_d;
            b_q  <= b_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign HI  = hi_q;
    assign LO  = lo_q;
    assign out = (MDUCtrl == MDUCtrl_MFHI) ? hi_q :
                 (MDUCtrl == MDUCtrl_MFLO) ? lo_q : 32'h0;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed vector table, hand sequences for busy-window
// corner cases, and random ops checked against an arithmetic reference model.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [3:0]  MDUCtrl;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] HI, LO, out_w;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] cur_hi, cur_lo;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[13];

    mul_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .MDUCtrl (MDUCtrl),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .HI      (HI),
        .LO      (LO),
        .out     (out_w)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic int cycles_of(input logic [3:0] op);
        if (op == MDUCtrl_MULT || op == MDUCtrl_MULTU) return MC;
        if (op == MDUCtrl_DIV || op == MDUCtrl_DIVU) return DC;
        return 0;
    endfunction

    // Reference: MIPS HI/LO semantics in plain 64-bit arithmetic.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi_in, input logic [31:0] lo_in,
                         output logic [31:0] hi_out, output logic [31:0] lo_out);
        int          sa, sb;
        longint      p, q, r;
        logic [63:0] pu;
        sa = a;
        sb = b;
        hi_out = hi_in;
        lo_out = lo_in;
        case (op)
            MDUCtrl_MULT: begin
                p = longint'(sa) * longint'(sb);
                hi_out = p[63:32];
                lo_out = p[31:0];
            end
            MDUCtrl_MULTU: begin
                pu = 64'(a) * 64'(b);
                hi_out = pu[63:32];
                lo_out = pu[31:0];
            end
            MDUCtrl_DIV: if (b != 0) begin
                q = longint'(sa) / longint'(sb);
                r = longint'(sa) % longint'(sb);
                hi_out = r[31:0];
                lo_out = q[31:0];
            end
            MDUCtrl_DIVU: if (b != 0) begin
                hi_out = a % b;
                lo_out = a / b;
            end
            MDUCtrl_MTHI: hi_out = a;
            MDUCtrl_MTLO: lo_out = a;
            default: ;
        endcase
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start   = 1'b1;
        MDUCtrl = op;
        A       = a;
        B       = b;
        @(posedge clk);
        #1;
        start   = 1'b0;
        MDUCtrl = MDUCtrl_NONE;
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        n = cycles_of(op);
        issue(op, a, b);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({name, ".busy_on"}, 32'(busy), 32'd1);
            check({name, ".hi_hold"}, HI, cur_hi);
            check({name, ".lo_hold"}, LO, cur_lo);
        end
        @(negedge clk);
        check({name, ".busy_off"}, 32'(busy), 32'd0);
        check({name, ".hi"}, HI, exp_hi);
        check({name, ".lo"}, LO, exp_lo);
        cur_hi = exp_hi;
        cur_lo = exp_lo;
        MDUCtrl = MDUCtrl_MFHI;
        #1 check({name, ".out_mfhi"}, out_w, exp_hi);
        MDUCtrl = MDUCtrl_MFLO;
        #1 check({name, ".out_mflo"}, out_w, exp_lo);
        MDUCtrl = MDUCtrl_NONE;
        #1 check({name, ".out_none"}, out_w, 32'h0);
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb, mh, ml;
        logic [3:0]  ops[6];

        vecs[0]  = '{"mult_neg",   MDUCtrl_MULT,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1]  = '{"multu_big",  MDUCtrl_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
        vecs[2]  = '{"div_neg",    MDUCtrl_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{"divu_7_2",   MDUCtrl_DIVU,  32'd7,        32'd2,        32'h00000001, 32'h00000003};
        vecs[4]  = '{"div_ovf",    MDUCtrl_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{"mthi",       MDUCtrl_MTHI,  32'h000000AA, 32'd0,        32'h000000AA, 32'h80000000};
        vecs[6]  = '{"mtlo",       MDUCtrl_MTLO,  32'h000000BB, 32'd0,        32'h000000AA, 32'h000000BB};
        vecs[7]  = '{"div_zero",   MDUCtrl_DIV,   32'd5,        32'd0,        32'h000000AA, 32'h000000BB};
        vecs[8]  = '{"div_negdiv", MDUCtrl_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[9]  = '{"multu_max",  MDUCtrl_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[10] = '{"mult_min",   MDUCtrl_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[11] = '{"start_mfhi", MDUCtrl_MFHI,  32'h12345678, 32'd3,        32'h40000000, 32'h00000000};
        vecs[12] = '{"divu_max",   MDUCtrl_DIVU,  32'hFFFFFFFF, 32'd10,       32'h00000005, 32'h19999999};

        reset = 1'b1; start = 1'b0; MDUCtrl = MDUCtrl_NONE; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.hi", HI, 32'h0);
        check("reset.lo", LO, 32'h0);
        cur_hi = 32'h0;
        cur_lo = 32'h0;

        for (int i = 0; i < 13; i++)
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

        // MTLO issued mid-multiply must be dropped; out keeps showing the old LO.
        issue(MDUCtrl_MULTU, 32'd3, 32'd4);
        for (int i = 1; i <= MC; i++) begin
            @(negedge clk);
            check("mtlo_busy.busy_on", 32'(busy), 32'd1);
            MDUCtrl = MDUCtrl_MFLO;
            #1 check("mtlo_busy.out_old", out_w, cur_lo);
            if (i == 2) begin
                start = 1'b1; MDUCtrl = MDUCtrl_MTLO; A = 32'h1234;
                @(posedge clk);
                #1 start = 1'b0;
            end
            MDUCtrl = MDUCtrl_NONE;
        end
        @(negedge clk);
        check("mtlo_busy.busy_off", 32'(busy), 32'd0);
        check("mtlo_busy.lo", LO, 32'd12);
        check("mtlo_busy.hi", HI, 32'd0);
        cur_hi = 32'd0; cur_lo = 32'd12;

        // Reset on busy cycle 3 aborts the divide with no late write.
        issue(MDUCtrl_DIV, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i <= DC; i++) begin
            @(negedge clk);
            check("abort.busy", 32'(busy), 32'd0);
            check("abort.hi", HI, 32'd0);
            check("abort.lo", LO, 32'd0);
        end
        cur_hi = 32'd0; cur_lo = 32'd0;

        // Reset wins over a simultaneous MTHI.
        @(negedge clk);
        reset = 1'b1; start = 1'b1; MDUCtrl = MDUCtrl_MTHI; A = 32'hDEAD;
        @(posedge clk);
        #1 reset = 1'b0; start = 1'b0; MDUCtrl = MDUCtrl_NONE;
        @(negedge clk);
        check("rst_prio.hi", HI, 32'd0);

        run_op("mtlo_1234", MDUCtrl_MTLO, 32'h1234, 32'd0, 32'd0, 32'h1234);

        ops = '{MDUCtrl_MULT, MDUCtrl_MULTU, MDUCtrl_DIV, MDUCtrl_DIVU, MDUCtrl_MTHI, MDUCtrl_MTLO};
        for (int k = 0; k < 40; k++) begin
            rop = ops[$urandom_range(0, 5)];
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
            model(rop, ra, rb, cur_hi, cur_lo, mh, ml);
            run_op("rand", rop, ra, rb, mh, ml);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
